// File: rtl/regincr_pkg.sv
// Shared definitions for schedulers that time-share a registered incrementer.
package regincr_pkg;

   localparam int REGINCR_NBITS = 8;

   typedef enum logic {
      RI_EMPTY = 1'b0,
      RI_FULL  = 1'b1
   } regincr_state_t;

   // Position reached by stepping 'off' places from 'base' around a ring of 'n'.
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/regincr_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping around the ring. Nothing is granted while i_en is low.
module regincr_rr_picker
   import regincr_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   int unsigned w_pos;

   // Walk the ring from the pointer and latch onto the first requester found.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = 32'd0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = rr_index(32'(i_ptr), 32'(k), 32'(NREQ));
         if (i_en && !o_any && i_req[w_pos[IW-1:0]]) begin
            o_grant[w_pos[IW-1:0]] = 1'b1;
            o_idx                  = w_pos[IW-1:0];
            o_any                  = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/regincr_rr_scheduler.sv
// Shares one registered +1 datapath among NREQ val/rdy requesters. A
// round-robin picker admits one operand per cycle into a single result
// register, which is presented with its owner's id on the response port.
module regincr_rr_scheduler
   import regincr_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NBITS = REGINCR_NBITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_val,
   output logic [NREQ-1:0]          req_rdy,
   input  logic [NREQ*NBITS-1:0]    req_msg,
   output logic                     resp_val,
   input  logic                     resp_rdy,
   output logic [NBITS-1:0]         resp_msg,
   output logic [$clog2(NREQ)-1:0]  resp_id
);

   localparam int IW = $clog2(NREQ);

   regincr_state_t   r_state;
   regincr_state_t   w_state_nxt;
   logic [NBITS-1:0] r_resp_msg;
   logic [IW-1:0]    r_resp_id;
   logic [IW-1:0]    r_rr_ptr;

   logic             w_can_accept;
   logic             w_en;
   logic [NREQ-1:0]  w_grant;
   logic [IW-1:0]    w_idx;
   logic             w_any;
   logic [NBITS-1:0] w_msg_sel;
   logic [NBITS-1:0] w_sum;
   logic [IW-1:0]    w_ptr_nxt;

   // The slot frees up either when empty or when the held result leaves now.
   // Gating with reset keeps req_rdy low for the whole reset window.
   assign resp_val     = (r_state == RI_FULL);
   assign w_can_accept = (r_state == RI_EMPTY) | (resp_val & resp_rdy);
   assign w_en         = w_can_accept & reset;

   regincr_rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .i_req   (req_val),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_en),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // A grant is a fire: req_val is already qualified inside the picker.
   assign req_rdy   = w_grant;
   assign w_msg_sel = req_msg[w_idx*NBITS +: NBITS];
   assign w_sum     = w_msg_sel + NBITS'(1);
   assign w_ptr_nxt = IW'(rr_index(32'(w_idx), 32'd1, 32'(NREQ)));
   assign resp_msg  = r_resp_msg;
   assign resp_id   = r_resp_id;

   // Next-state logic: a fire always leaves a result held, even when the
   // previous one drains in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RI_EMPTY: begin
            if (w_any) begin
               w_state_nxt = RI_FULL;
            end else begin
               w_state_nxt = RI_EMPTY;
            end
         end
         RI_FULL: begin
            if (w_any) begin
               w_state_nxt = RI_FULL;
            end else if (resp_rdy) begin
               w_state_nxt = RI_EMPTY;
            end else begin
               w_state_nxt = RI_FULL;
            end
         end
         default: w_state_nxt = RI_EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RI_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result register and fairness pointer; both move only on a fire.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_resp_msg <= '0;
         r_resp_id  <= '0;
         r_rr_ptr   <= '0;
      end else if (w_any) begin
         r_resp_msg <= w_sum;
         r_resp_id  <= w_idx;
         r_rr_ptr   <= w_ptr_nxt;
      end else begin
         r_resp_msg <= r_resp_msg;
         r_resp_id  <= r_resp_id;
         r_rr_ptr   <= r_rr_ptr;
      end
   end

`ifndef SYNTHESIS
   // One-line trace: req_val > grant | state | id:msg
   function automatic string line_trace();
      string s_grant;
      if (w_any) begin
         s_grant = $sformatf("%0d", w_idx);
      end else begin
         s_grant = ".";
      end
      return $sformatf("%b > %s | %s | %0d:%h", req_val, s_grant,
                       (r_state == RI_FULL) ? "F" : "E", r_resp_id, r_resp_msg);
   endfunction
`endif

endmodule

// File: tb/tb_regincr_rr_scheduler.sv
// Bench for regincr_rr_scheduler (NREQ=4, NBITS=8): a vector table, a few
// directed multi-cycle sequences and a randomized run against a reference model.
module tb_regincr_rr_scheduler;

   localparam int NREQ  = 4;
   localparam int NBITS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_val;
   logic [3:0]  req_rdy;
   logic [31:0] req_msg;
   logic        resp_val;
   logic        resp_rdy;
   logic [7:0]  resp_msg;
   logic [1:0]  resp_id;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (spec level: occupancy flag and next-priority port).
   bit m_full;
   int m_ptr;

   always #5 clk = ~clk;

   regincr_rr_scheduler #(.NREQ(NREQ), .NBITS(NBITS)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_msg  (req_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_msg (resp_msg),
      .resp_id  (resp_id)
   );

   typedef struct {
      logic [3:0]  val;
      logic [31:0] msg;
      logic        rr;
      logic [3:0]  exp_rdy;
      logic        exp_val;
      logic [7:0]  exp_msg;
      logic [1:0]  exp_id;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] m, input logic rr);
      @(negedge clk);
      req_val  = v;
      req_msg  = m;
      resp_rdy = rr;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b0;
      req_val  = 4'hF;
      req_msg  = 32'h0;
      resp_rdy = 1'b1;
      #1;
      check("rst_req_rdy", int'(req_rdy), 0);
      @(negedge clk);
      check("rst_resp_val", int'(resp_val), 0);
      check("rst_resp_msg", int'(resp_msg), 0);
      check("rst_resp_id", int'(resp_id), 0);
      reset   = 1'b1;
      req_val = 4'h0;
      m_full  = 1'b0;
      m_ptr   = 0;
   endtask

   // Round-robin choice from the rules: first valid port at or after m_ptr.
   function automatic int model_grant(input logic [3:0] v);
      for (int off = 0; off < NREQ; off++) begin
         if (v[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
      end
      return -1;
   endfunction

   bit          pend[4];
   logic [7:0]  op[4];
   int          waitc[4];
   int          sb[4][$];

   initial begin
      logic [3:0]  v;
      logic [31:0] m;
      logic        rr;
      int          g;
      int          exp_v;

      reset    = 1'b0;
      req_val  = 4'h0;
      req_msg  = 32'h0;
      resp_rdy = 1'b0;

      vecs[0]  = '{4'b0100, 32'h0041_0000, 1'b1, 4'b0100, 1'b1, 8'h42, 2'd2};
      vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h42, 2'd2};
      vecs[2]  = '{4'b0010, 32'h0000_FF00, 1'b1, 4'b0010, 1'b1, 8'h00, 2'd1};
      vecs[3]  = '{4'b0001, 32'h0000_0000, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0};
      vecs[4]  = '{4'b1111, 32'h4030_2010, 1'b0, 4'b0000, 1'b1, 8'h01, 2'd0};
      vecs[5]  = '{4'b1111, 32'h4030_2010, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1};
      vecs[6]  = '{4'b1111, 32'h4030_2010, 1'b1, 4'b0100, 1'b1, 8'h31, 2'd2};
      vecs[7]  = '{4'b1001, 32'h4030_2010, 1'b1, 4'b1000, 1'b1, 8'h41, 2'd3};
      vecs[8]  = '{4'b1001, 32'h4030_2010, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      vecs[9]  = '{4'b1111, 32'h4030_2010, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1};
      vecs[10] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h21, 2'd1};

      // Vector table from a clean reset.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].val, vecs[i].msg, vecs[i].rr);
         check($sformatf("tbl%0d_req_rdy", i), int'(req_rdy), int'(vecs[i].exp_rdy));
         step();
         check($sformatf("tbl%0d_resp_val", i), int'(resp_val), int'(vecs[i].exp_val));
         check($sformatf("tbl%0d_resp_msg", i), int'(resp_msg), int'(vecs[i].exp_msg));
         check($sformatf("tbl%0d_resp_id", i), int'(resp_id), int'(vecs[i].exp_id));
      end

      // All four requesters valid: grants rotate 0,1,2,3,0,...
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(4'hF, 32'h0302_0100, 1'b1);
         check("rot_req_rdy", int'(req_rdy), 1 << (k % NREQ));
         step();
         check("rot_resp_id", int'(resp_id), k % NREQ);
         check("rot_resp_msg", int'(resp_msg), (k % NREQ) + 1);
      end

      // Stall: port 1 keeps requesting while the response is blocked.
      do_reset();
      drive(4'b0010, 32'h0000_0700, 1'b0);
      check("stall_first_rdy", int'(req_rdy), 2);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(4'b0010, 32'h0000_0900, 1'b0);
         check("stall_req_rdy", int'(req_rdy), 0);
         check("stall_resp_msg", int'(resp_msg), 8'h08);
         check("stall_resp_id", int'(resp_id), 1);
         step();
      end
      drive(4'b0010, 32'h0000_0900, 1'b1);
      check("drain_fire_rdy", int'(req_rdy), 2);
      step();
      check("drain_fire_val", int'(resp_val), 1);
      check("drain_fire_msg", int'(resp_msg), 8'h0A);

      // Reset while FULL: resp_val drops without a clock edge.
      do_reset();
      drive(4'b0100, 32'h0005_0000, 1'b1);
      step();
      check("pre_rst_full", int'(resp_val), 1);
      drive(4'hF, 32'h4030_2010, 1'b0);
      #1 reset = 1'b0;
      #1;
      check("async_resp_val", int'(resp_val), 0);
      check("async_req_rdy", int'(req_rdy), 0);
      check("async_resp_msg", int'(resp_msg), 0);
      @(negedge clk);
      reset    = 1'b1;
      resp_rdy = 1'b1;
      #1;
      check("post_rst_grant", int'(req_rdy), 1);
      step();
      check("post_rst_id", int'(resp_id), 0);
      check("post_rst_msg", int'(resp_msg), 8'h11);

      // Randomized traffic against the reference model and per-id scoreboards.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         pend[i]  = 1'b0;
         op[i]    = 8'h00;
         waitc[i] = 0;
         sb[i].delete();
      end
      for (int cyc = 0; cyc < 506; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (cyc < 500 && !pend[i] && $urandom_range(0, 99) < 50) begin
               pend[i] = 1'b1;
               op[i]   = 8'($urandom_range(0, 255));
            end
         end
         v  = {pend[3], pend[2], pend[1], pend[0]};
         m  = {op[3], op[2], op[1], op[0]};
         rr = (cyc >= 500) ? 1'b1 : ($urandom_range(0, 99) < 70);
         drive(v, m, rr);
         check("rnd_resp_val", int'(resp_val), int'(m_full));
         if (resp_val && rr) begin
            check("rnd_sb_nonempty", int'(sb[resp_id].size() > 0), 1);
            if (sb[resp_id].size() > 0) begin
               exp_v = sb[resp_id].pop_front();
               check("rnd_resp_msg", int'(resp_msg), exp_v);
            end
         end
         g = (!m_full || rr) ? model_grant(v) : -1;
         check("rnd_req_rdy", int'(req_rdy), (g >= 0) ? (1 << g) : 0);
         if (g >= 0) begin
            check("rnd_no_starve", int'(waitc[g] < NREQ), 1);
            waitc[g] = 0;
            for (int i = 0; i < NREQ; i++) begin
               if (i != g && pend[i]) waitc[i]++;
            end
            sb[g].push_back((int'(op[g]) + 1) % 256);
            pend[g] = 1'b0;
         end
         step();
         if (g >= 0) begin
            m_full = 1'b1;
            m_ptr  = (g + 1) % NREQ;
         end else if (rr) begin
            m_full = 1'b0;
         end
      end
      check("rnd_final_val", int'(resp_val), 0);
      for (int i = 0; i < NREQ; i++) begin
         check("rnd_sb_drained", sb[i].size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
